// File: rtl/exe_muldiv.sv
// Execute-stage multiply/divide unit owning HI/LO: single-cycle MULT/MULTU/MTHI/MTLO,
// 32-iteration restoring divide with a Mealy stall request to the pipeline.
module exe_muldiv #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_da,
  input  logic [31:0] i_db,
  input  logic        i_hold,
  input  logic        i_flush,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_stallreq,
  output logic        o_busy
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [64:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;

  logic        stallreq;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [63:0] mul_a, mul_b, prod;
  logic [64:0] shifted;
  logic [31:0] quot_fix, rem_fix;

  always_comb begin
    div_signed = (i_op == OP_DIV);
    a_neg      = div_signed & i_da[31];
    b_neg      = div_signed & i_db[31];
    mag_a      = a_neg ? (~i_da + 32'd1) : i_da;
    mag_b      = b_neg ? (~i_db + 32'd1) : i_db;

    // Sign-extending to 64 bits makes the low half of the product correct for both flavours.
    mul_a      = {{32{(i_op == OP_MULT) & i_da[31]}}, i_da};
    mul_b      = {{32{(i_op == OP_MULT) & i_db[31]}}, i_db};
    prod       = mul_a * mul_b;

    shifted    = {acc_q[63:0], 1'b0};
    quot_fix   = qneg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix    = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dvsr_d   = dvsr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    stallreq = 1'b0;

    case (state_q)
      S_IDLE: begin
        case (i_op)
          OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
          OP_MTHI:           hi_d = i_da;
          OP_MTLO:           lo_d = i_da;
          OP_DIV, OP_DIVU: begin
            stallreq = 1'b1;
            dvsr_d   = mag_b;
            cnt_d    = 6'd0;
            if (i_db == 32'd0) begin
              // Divide by zero: result stored raw so DONE's sign fix-up leaves it untouched.
              acc_d   = {1'b0, i_da, 32'hFFFF_FFFF};
              qneg_d  = 1'b0;
              rneg_d  = 1'b0;
              state_d = S_DONE;
            end else begin
              acc_d   = {33'd0, mag_a};
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
              state_d = S_DIV;
            end
          end
          default: ;
        endcase
      end
      S_DIV: begin
        stallreq = 1'b1;
        if (shifted[64:32] >= {1'b0, dvsr_q})
          acc_d = {shifted[64:32] - {1'b0, dvsr_q}, shifted[31:1], 1'b1};
        else
          acc_d = shifted;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_CYCLES - 1))
          state_d = S_DONE;
      end
      S_DONE: begin
        hi_d = rem_fix;
        lo_d = quot_fix;
        if (!i_hold)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (i_flush) begin
      state_d  = S_IDLE;
      hi_d     = hi_q;
      lo_d     = lo_q;
      stallreq = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      dvsr_q  <= 32'd0;
      acc_q   <= 65'd0;
      cnt_q   <= 6'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvsr_q  <= dvsr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign o_hi       = hi_q;
  assign o_lo       = lo_q;
  assign o_stallreq = stallreq;
  assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_exe_muldiv.sv
// Bench for exe_muldiv: directed vector table, random ops against an arithmetic model,
// and hand-written hold / flush / reset sequences.
module tb_exe_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  i_op;
  logic [31:0] i_da, i_db;
  logic        i_hold, i_flush;
  logic [31:0] o_hi, o_lo;
  logic        o_stallreq, o_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  exe_muldiv #(.DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .i_op(i_op), .i_da(i_da), .i_db(i_db),
    .i_hold(i_hold), .i_flush(i_flush), .o_hi(o_hi), .o_lo(o_lo),
    .o_stallreq(o_stallreq), .o_busy(o_busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] da, db, hi, lo;
    int          stalls;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result from plain arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] da,
                                        input logic [31:0] db, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint a, b, q, r;
    logic [63:0] res;
    res = {hi, lo};
    case (op)
      3'd1: begin a = $signed(da); b = $signed(db); res = a * b; end
      3'd2: res = {32'd0, da} * {32'd0, db};
      3'd3, 3'd4: begin
        if (db == 32'd0) res = {da, 32'hFFFF_FFFF};
        else begin
          if (op == 3'd3) begin a = $signed(da); b = $signed(db); end
          else begin a = {32'd0, da}; b = {32'd0, db}; end
          q = a / b;
          r = a % b;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd5: res = {da, lo};
      3'd6: res = {hi, da};
      default: ;
    endcase
    return res;
  endfunction

  function automatic int model_stalls(input logic [2:0] op, input logic [31:0] db);
    if (op == 3'd3 || op == 3'd4) return (db == 32'd0) ? 1 : 33;
    return 0;
  endfunction

  // Entered and left just after a rising edge; runs one instruction to completion.
  task automatic run_op(input logic [2:0] op, input logic [31:0] da, input logic [31:0] db,
                        output int stalls);
    logic fin;
    fin = 1'b0;
    stalls = 0;
    i_op = op; i_da = da; i_db = db;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_stallreq) stalls++;
      else fin = 1'b1;
      @(posedge clk); #1;
      if (fin) break;
    end
    if (!fin) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: op %0d stall never dropped", op);
    end
    i_op = 3'd0;
  endtask

  initial begin
    int st;
    logic [63:0] exp;
    logic [31:0] m_hi, m_lo;
    logic [2:0]  rop;
    logic [31:0] rda, rdb;

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0};
    vecs[1] = '{3'd2, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 0};
    vecs[2] = '{3'd4, 32'd100, 32'd7, 32'h2, 32'hE, 33};
    vecs[3] = '{3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[4] = '{3'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1};
    vecs[5] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33};
    vecs[6] = '{3'd5, 32'h55, 32'h0, 32'h55, 32'h8000_0000, 0};
    vecs[7] = '{3'd6, 32'h66, 32'h0, 32'h55, 32'h66, 0};

    reset = 1'b1; i_op = 3'd0; i_da = 32'd0; i_db = 32'd0; i_hold = 1'b0; i_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_hi", o_hi, 32'd0);
    check("reset_lo", o_lo, 32'd0);
    check("reset_stall", {31'd0, o_stallreq}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].da, vecs[i].db, st);
      check($sformatf("vec%0d_hi", i), o_hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), o_lo, vecs[i].lo);
      check($sformatf("vec%0d_stalls", i), st, vecs[i].stalls);
      $display("vec %0d op=%0d da=%h db=%h -> hi=%h lo=%h stalls=%0d",
               i, vecs[i].op, vecs[i].da, vecs[i].db, o_hi, o_lo, st);
    end

    m_hi = o_hi; m_lo = o_lo;
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(1, 6));
      rda = $urandom;
      case ($urandom_range(0, 7))
        0:       rdb = 32'd0;
        1, 2:    rdb = $urandom_range(1, 20);
        3:       rdb = 32'hFFFF_FFFF;
        default: rdb = $urandom;
      endcase
      exp = model(rop, rda, rdb, m_hi, m_lo);
      run_op(rop, rda, rdb, st);
      check($sformatf("rnd%0d_hi", i), o_hi, exp[63:32]);
      check($sformatf("rnd%0d_lo", i), o_lo, exp[31:0]);
      check($sformatf("rnd%0d_stalls", i), st, model_stalls(rop, rdb));
      $display("rnd %0d op=%0d da=%h db=%h -> hi=%h lo=%h stalls=%0d",
               i, rop, rda, rdb, o_hi, o_lo, st);
      m_hi = exp[63:32]; m_lo = exp[31:0];
    end

    // DIVU 100/7 held in DONE for five cycles with the opcode still present.
    st = 0;
    i_op = 3'd4; i_da = 32'd100; i_db = 32'd7;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!o_stallreq) break;
      st++;
      @(posedge clk); #1;
    end
    check("hold_stalls", st, 33);
    i_hold = 1'b1;
    check("hold_busy0", {31'd0, o_busy}, 32'd1);
    for (int k = 1; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("hold_busy%0d", k), {31'd0, o_busy}, 32'd1);
      check($sformatf("hold_stall%0d", k), {31'd0, o_stallreq}, 32'd0);
    end
    i_hold = 1'b0;
    @(posedge clk); #1;
    i_op = 3'd0;
    check("hold_idle", {31'd0, o_busy}, 32'd0);
    check("hold_hi", o_hi, 32'd2);
    check("hold_lo", o_lo, 32'd14);
    $display("hold seq: hi=%h lo=%h", o_hi, o_lo);

    // Flush at iteration 10 of DIV 50/5 after preloading HI.
    run_op(3'd5, 32'hAAAA_0000, 32'd0, st);
    i_op = 3'd3; i_da = 32'd50; i_db = 32'd5;
    repeat (11) @(posedge clk);
    #1;
    i_flush = 1'b1;
    @(negedge clk);
    check("flush_stall", {31'd0, o_stallreq}, 32'd0);
    @(posedge clk); #1;
    i_flush = 1'b0; i_op = 3'd0;
    @(negedge clk);
    check("flush_idle", {31'd0, o_busy}, 32'd0);
    check("flush_stall_after", {31'd0, o_stallreq}, 32'd0);
    check("flush_hi", o_hi, 32'hAAAA_0000);
    @(posedge clk); #1;
    run_op(3'd4, 32'd9, 32'd4, st);
    check("post_flush_lo", o_lo, 32'd2);
    check("post_flush_hi", o_hi, 32'd1);
    check("post_flush_stalls", st, 33);
    $display("flush seq: hi=%h lo=%h", o_hi, o_lo);

    // Reset at iteration 20 of a divide.
    i_op = 3'd4; i_da = 32'd100; i_db = 32'd7;
    repeat (21) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    i_op = 3'd0;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    check("rst_mid_stall", {31'd0, o_stallreq}, 32'd0);
    check("rst_mid_hi", o_hi, 32'd0);
    check("rst_mid_lo", o_lo, 32'd0);
    $display("reset seq: busy=%0d hi=%h lo=%h", o_busy, o_hi, o_lo);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
